// File: rtl/balanced_line_tx.sv
// Manchester transmitter for the balanced link: start bit + MSB-first payload,
// each frame followed by a guaranteed low idle gap.
module balanced_line_tx #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned GAP_BITS   = 2
) (
   input  logic                  clk,
   input  logic                  globalResetN,
   input  logic [3:0]            halfBitLen,
   input  logic [DATA_WIDTH-1:0] txData,
   input  logic                  txValid,
   output logic                  txReady,
   output logic                  balancedCLK,
   output logic                  lineIdle,
   output logic                  frameDone
);

   localparam int unsigned SW = DATA_WIDTH + 1;
   localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
   localparam int unsigned GW = 9;
   localparam logic [GW-1:0] GAP_FULL = GW'(2 * 16 * GAP_BITS - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH);

   typedef enum logic [1:0] {
      S_GAP  = 2'd0,
      S_WAIT = 2'd1,
      S_SEND = 2'd2
   } state_t;

   // Gap reload value 2*H*GAP_BITS-1, with a code of 0 meaning H=16.
   function automatic logic [GW-1:0] gap_load(input logic [3:0] h);
      logic [4:0] he;
      he = (h == 4'd0) ? 5'd16 : {1'b0, h};
      return GW'(32'(he) * 32'(2 * GAP_BITS) - 32'd1);
   endfunction

   state_t         state, state_n;
   logic [3:0]     hc, hc_n;
   logic           phase, phase_n;
   logic [BW-1:0]  bitcnt, bitcnt_n;
   logic [GW-1:0]  gc, gc_n;
   logic [SW-1:0]  sh, sh_n;
   logic [3:0]     h_q, h_q_n;
   logic           h_pend, h_pend_n;
   logic           line_n, ready_n, idle_n, done_n;

   // State and datapath registers; reset forces the line low immediately.
   always_ff @(posedge clk or negedge globalResetN) begin
      if (!globalResetN) begin
         state       <= S_GAP;
         hc          <= '0;
         phase       <= 1'b0;
         bitcnt      <= '0;
         gc          <= GAP_FULL;
         sh          <= '0;
         h_q         <= '0;
         h_pend      <= 1'b1;
         balancedCLK <= 1'b0;
         txReady     <= 1'b0;
         lineIdle    <= 1'b1;
         frameDone   <= 1'b0;
      end else begin
         state       <= state_n;
         hc          <= hc_n;
         phase       <= phase_n;
         bitcnt      <= bitcnt_n;
         gc          <= gc_n;
         sh          <= sh_n;
         h_q         <= h_q_n;
         h_pend      <= h_pend_n;
         balancedCLK <= line_n;
         txReady     <= ready_n;
         lineIdle    <= idle_n;
         frameDone   <= done_n;
      end
   end

   // Next-state logic; outputs are derived from next state so they register cleanly.
   always_comb begin
      state_n  = state;
      hc_n     = hc;
      phase_n  = phase;
      bitcnt_n = bitcnt;
      gc_n     = gc;
      sh_n     = sh;
      h_q_n    = h_q;
      h_pend_n = h_pend;
      line_n   = balancedCLK;

      case (state)
         S_GAP: begin
            line_n = 1'b0;
            if (h_pend) begin
               // First cycle after reset release samples H and arms the gap.
               h_q_n    = halfBitLen;
               gc_n     = gap_load(halfBitLen);
               h_pend_n = 1'b0;
            end else if (gc == '0) begin
               state_n = S_WAIT;
            end else begin
               gc_n = gc - GW'(1);
            end
         end
         S_WAIT: begin
            line_n = 1'b0;
            if (txValid && txReady) begin
               state_n  = S_SEND;
               h_q_n    = halfBitLen;
               hc_n     = halfBitLen - 4'd1;
               phase_n  = 1'b0;
               bitcnt_n = '0;
               sh_n     = {1'b0, txData};
               line_n   = 1'b0;
            end
         end
         S_SEND: begin
            if (hc != 4'd0) begin
               hc_n = hc - 4'd1;
            end else if (!phase) begin
               phase_n = 1'b1;
               hc_n    = h_q - 4'd1;
               line_n  = ~sh[SW-1];
            end else if (bitcnt == LAST_BIT) begin
               state_n = S_GAP;
               line_n  = 1'b0;
               gc_n    = gap_load(h_q);
            end else begin
               bitcnt_n = bitcnt + BW'(1);
               sh_n     = {sh[SW-2:0], 1'b0};
               phase_n  = 1'b0;
               hc_n     = h_q - 4'd1;
               line_n   = sh[SW-2];
            end
         end
         default: begin
            state_n = S_GAP;
            line_n  = 1'b0;
         end
      endcase

      ready_n = (state_n == S_WAIT);
      idle_n  = (state_n != S_SEND);
      done_n  = (state_n == S_SEND) && (hc_n == 4'd0) && phase_n && (bitcnt_n == LAST_BIT);
   end

endmodule

// File: tb/tb_balanced_line_tx.sv
// Directed + randomized bench for balanced_line_tx; expected line levels are
// computed per cycle from the Manchester frame definition.
module tb_balanced_line_tx;

   localparam int unsigned W = 8;
   localparam int unsigned G = 2;

   logic         clk = 1'b0;
   logic         globalResetN;
   logic [3:0]   halfBitLen;
   logic [W-1:0] txData;
   logic         txValid;
   logic         txReady;
   logic         balancedCLK;
   logic         lineIdle;
   logic         frameDone;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   balanced_line_tx #(.DATA_WIDTH(W), .GAP_BITS(G)) dut (
      .clk         (clk),
      .globalResetN(globalResetN),
      .halfBitLen  (halfBitLen),
      .txData      (txData),
      .txValid     (txValid),
      .txReady     (txReady),
      .balancedCLK (balancedCLK),
      .lineIdle    (lineIdle),
      .frameDone   (frameDone)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic int heff(input logic [3:0] h);
      return (h == 4'd0) ? 16 : int'(h);
   endfunction

   // Cycle k of a frame: bit index k/(2H), half (k/H)%2; bit 0 is the start bit.
   function automatic logic model_line(input logic [W-1:0] d, input int h, input int k);
      int   b;
      logic bv;
      b  = k / (2 * h);
      bv = (b == 0) ? 1'b0 : d[W-b];
      return ((k / h) % 2 == 1) ? ~bv : bv;
   endfunction

   // First posedge inside is the accept edge; checks every cycle of the frame.
   task automatic check_frame(input logic [W-1:0] d, input int h, input bit hold,
                              input logic [W-1:0] next_d, input int chg_k,
                              input logic [3:0] chg_h, input int abort_k);
      int f;
      f = 2 * h * int'(W + 1);
      for (int k = 0; k < f; k++) begin
         @(posedge clk); #1;
         if (k == 0) txData = next_d;
         if (k == chg_k) halfBitLen = chg_h;
         if (k == abort_k) begin
            globalResetN = 1'b0;
            txValid      = 1'b0;
            #1;
            chk($sformatf("abort_line k=%0d", k), balancedCLK, 1'b0);
            chk("abort_ready", txReady, 1'b0);
            chk("abort_idle", lineIdle, 1'b1);
            chk("abort_done", frameDone, 1'b0);
            return;
         end
         chk($sformatf("line d=%h h=%0d k=%0d", d, h, k), balancedCLK, model_line(d, h, k));
         chk($sformatf("done k=%0d", k), frameDone, k == f - 1);
         chk($sformatf("ready_send k=%0d", k), txReady, 1'b0);
         chk($sformatf("idle_send k=%0d", k), lineIdle, 1'b0);
         if (!hold) txValid = (k < f - 1) ? 1'($urandom) : 1'b0;
      end
   endtask

   // Gap of 2*H*G low cycles with txReady low, then txReady rises.
   task automatic check_gap(input int h, input bit hold);
      int g;
      g = 2 * h * int'(G);
      for (int i = 0; i < g; i++) begin
         @(posedge clk); #1;
         chk($sformatf("gap_line i=%0d", i), balancedCLK, 1'b0);
         chk($sformatf("gap_idle i=%0d", i), lineIdle, 1'b1);
         chk($sformatf("gap_ready i=%0d h=%0d", i, h), txReady, 1'b0);
         chk($sformatf("gap_done i=%0d", i), frameDone, 1'b0);
         if (!hold) txValid = (i < g - 1) ? 1'($urandom) : 1'b0;
      end
      @(posedge clk); #1;
      chk("wait_ready", txReady, 1'b1);
      chk("wait_idle", lineIdle, 1'b1);
      chk("wait_line", balancedCLK, 1'b0);
   endtask

   task automatic stall(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk("stall_ready", txReady, 1'b1);
         chk("stall_line", balancedCLK, 1'b0);
      end
   endtask

   task automatic send(input logic [W-1:0] d, input logic [3:0] hn, input int chg_k,
                       input logic [3:0] chg_h);
      txData     = d;
      halfBitLen = hn;
      txValid    = 1'b1;
      check_frame(d, heff(hn), 1'b0, W'($urandom), chg_k, chg_h, -1);
      check_gap(heff(hn), 1'b0);
   endtask

   initial begin
      logic [W-1:0] d;
      logic [3:0]   hn;

      globalResetN = 1'b0;
      halfBitLen   = 4'd8;
      txData       = '0;
      txValid      = 1'b0;

      // Reset values and first gap after release.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_line", balancedCLK, 1'b0);
      chk("rst_ready", txReady, 1'b0);
      chk("rst_idle", lineIdle, 1'b1);
      chk("rst_done", frameDone, 1'b0);
      #2 globalResetN = 1'b1;
      check_gap(8, 1'b0);

      // 0xA5 at H=8.
      send(8'hA5, 4'd8, -1, 4'd0);

      // H=16 back-to-back 0x00 then 0xFF with txValid held high.
      txData     = 8'h00;
      halfBitLen = 4'd0;
      txValid    = 1'b1;
      check_frame(8'h00, 16, 1'b1, 8'hFF, -1, 4'd0, -1);
      check_gap(16, 1'b1);
      check_frame(8'hFF, 16, 1'b0, 8'h00, -1, 4'd0, -1);
      check_gap(16, 1'b0);

      // halfBitLen changes mid-frame: current frame and gap keep H=8.
      send(8'h3C, 4'd8, 10, 4'd3);
      stall(2);
      d       = W'($urandom);
      txData  = d;
      txValid = 1'b1;
      check_frame(d, 3, 1'b0, W'($urandom), -1, 4'd3, -1);
      check_gap(3, 1'b0);

      // Full-rate toggling at H=1.
      send(8'h5A, 4'd1, -1, 4'd0);

      // Randomized payloads and half-bit lengths.
      for (int n = 0; n < 6; n++) begin
         stall($urandom_range(0, 3));
         d  = W'($urandom);
         hn = 4'($urandom_range(0, 15));
         send(d, hn, $urandom_range(1, 30), 4'($urandom));
      end

      // Reset at cycle 50 of a frame, then full gap and recovery frame.
      txData     = 8'h00;
      halfBitLen = 4'd8;
      txValid    = 1'b1;
      check_frame(8'h00, 8, 1'b0, 8'h00, -1, 4'd0, 50);
      repeat (2) @(posedge clk);
      #3 globalResetN = 1'b1;
      check_gap(8, 1'b0);
      send(8'h81, 4'd5, -1, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/balanced_line_tx.md
# balanced_line_tx

Transmit end of the balanced (Manchester-coded) serial link into the LED control processor's digital control unit. Accepts parallel frames over a valid/ready handshake and serialises each one on `balancedCLK` as a start bit, then data bits MSB first. Each frame is followed by a guaranteed low idle gap, so the receiver's idle detector asserts `IDLE` between frames and resynchronises on the next start bit.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame (1..32).
- `GAP_BITS`, default 2: idle gap length in bit periods after every frame and after reset (1..15).
- `clk`  in  1: system clock; all state changes on rising edge.
- `globalResetN`  in  1: reset, asynchronous, active-low.
- `halfBitLen`  in  4: cycles per half-bit, H; value 0 means H=16.
- `txData`  in  DATA_WIDTH: frame payload.
- `txValid`  in  1: payload available.
- `txReady`  out  1: block can accept a frame; registered.
- `balancedCLK`  out  1: encoded serial line; registered, glitch-free.
- `lineIdle`  out  1: high while the line is in gap or wait (no frame on the wire).
- `frameDone`  out  1: one-cycle pulse on the last cycle of a frame's final half-bit.

## Operation
- Encoding:
  - bit 0 = low for H cycles, then high for H.
  - bit 1 = high for H, then low for H.
  - idle = line held low.
- Frame: start bit (always 0), then `txData[DATA_WIDTH-1]` down to `txData[0]`. Length is 2H·(DATA_WIDTH+1) cycles.
- FSM states: GAP, WAIT, SEND.
  - GAP: line low, `lineIdle`=1, `txReady`=0. Counts 2H·GAP_BITS cycles, then goes to WAIT.
  - WAIT: line low, `lineIdle`=1, `txReady`=1. Moves to SEND on `txValid && txReady`.
  - SEND: shifts out the frame. Goes to GAP after the final half-bit.
- Counters:
  - half-bit counter, 4 bits, counts H-1 down to 0.
  - half-bit phase flag.
  - bit counter, counts up to DATA_WIDTH.
  - gap counter, wide enough for 2·16·15.
  - shift register, DATA_WIDTH+1 bits, loaded with {1'b0, txData} on accept.
- H latching: `halfBitLen` is latched on accept and on reset release. The latched value governs the following SEND and GAP. Changes to the input at any other time are ignored.
- `txData` is captured on the accept edge; it may change afterwards.
- `txValid` during GAP or SEND is ignored (no accept, no queuing).
- Dropping `txValid` in WAIT without an accept is legal.

## Timing
- Reset values: state=GAP, `balancedCLK`=0, `txReady`=0, `lineIdle`=1, `frameDone`=0, all counters cleared. The gap counter is loaded for a full gap.
- After reset deassertion:
  - the first gap is 2H·GAP_BITS cycles, using H sampled in the first cycle after release;
  - `txReady` rises on the following edge.
- Accept edge → the next cycle's `balancedCLK` is the first cycle of the start bit's low half (1-cycle latency). `lineIdle` falls and `txReady` falls on that same edge.
- Every half-bit lasts exactly H cycles. There is no extra cycle at bit or frame boundaries.
- `frameDone` is high on the last cycle of SEND. On the next edge:
  - state=GAP;
  - `balancedCLK`=0;
  - `lineIdle`=1.
- Frame ending in bit 0 (line high): the line falls at the frame/gap boundary. Frame ending in bit 1: the line is already low.
- Minimum spacing between accept edges is 2H·(DATA_WIDTH+1) + 2H·GAP_BITS + 1 cycles.
- Reset mid-frame: the line drops to 0 asynchronously, the frame is abandoned, and a full gap precedes the next `txReady`.
- H=1: half-bits are single cycles, giving full-rate toggling. Line must still be correct.

## Test plan
- Reset release, H=8, GAP_BITS=2 → `balancedCLK`=0 and `lineIdle`=1 throughout. `txReady` rises exactly 32 cycles after release, counted from the first clock edge after release.
- H=8, W=8, send 0xA5 → line is start 0, then bits 1,0,1,0,0,1,0,1, each half 8 cycles.
  - Total frame = 144 cycles.
  - `frameDone` pulses once, at cycle 144 after accept.
  - Line is then low for 32 cycles before `txReady`=1.
- H=0 (H=16), send 0x00, then 0xFF back-to-back with `txValid` held high:
  - each frame is 288 cycles;
  - the gap between frames is exactly 64 low cycles;
  - the second accept happens on the first WAIT cycle.
- Change `halfBitLen` from 8 to 3 mid-frame → current frame stays at 8-cycle halves. The next frame uses 3-cycle halves.
- Assert `globalResetN`=0 at cycle 50 of a frame → line goes to 0 immediately and `txReady`=0. After release, a full gap occurs before `txReady`.
- Loopback: drive `balancedCLK` into the receiver `IDLEdetection` with REF4Bits=12, H=8 → `IDLE` is high during gaps, low within frames, and there are no false `IDLE` assertions inside a frame of all-0 bits.
